// File: rtl/cpu_mem_pkg.sv
// Shared widths, port ids and request bundle for the CPU data-memory path.
package cpu_mem_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

    // One requester's access: direction, word address and write data.
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; the "last granted" pointer is held by the caller.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // Port 0 wins a tie when port 1 was served last, otherwise port 1 wins.
    always_comb begin
        gnt = 2'b00;
        if (req[0] && (!req[1] || last)) begin
            gnt[0] = 1'b1;
        end else if (req[1]) begin
            gnt[1] = 1'b1;
        end
    end

endmodule

// File: rtl/data_ram_arbiter.sv
// Round-robin sequencer sharing the single Data_RAM port between the CPU
// load/store unit (port 0) and the loader (port 1). Grant in N, issue in N+1,
// read data returned with a one-cycle rvalid pulse in N+2.
module data_ram_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W = cpu_mem_pkg::ADDR_W,
    parameter int DATA_W = cpu_mem_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic              ram_write_enable,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out
);

    logic              last_q, last_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_din_q, ram_din_d;
    logic              rd_vld_q, rd_vld_d;   // read tag travelling with the issue
    logic              rd_port_q, rd_port_d;
    logic              rvalid0_q, rvalid0_d;
    logic              rvalid1_q, rvalid1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    logic [1:0] gnt_raw;
    logic       gnt_any;
    mem_req_t   req_sel;

    rr_arb2 u_arb (
        .req  ({req1, req0}),
        .last (last_q),
        .gnt  (gnt_raw)
    );

    // Grants are suppressed while reset is held so nothing is accepted then.
    assign gnt0    = gnt_raw[0] & ~reset;
    assign gnt1    = gnt_raw[1] & ~reset;
    assign gnt_any = gnt0 | gnt1;
    assign req_sel = gnt1 ? mem_req_t'{we1, addr1, wdata1}
                          : mem_req_t'{we0, addr0, wdata0};

    // Next-state: pointer, issue registers, read tag and per-port returns.
    always_comb begin
        last_d     = last_q;
        ram_we_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        rd_vld_d   = 1'b0;
        rd_port_d  = rd_port_q;
        if (gnt_any) begin
            last_d     = gnt1;
            ram_we_d   = req_sel.we;
            ram_addr_d = req_sel.addr;
            ram_din_d  = req_sel.wdata;
            rd_vld_d   = ~req_sel.we;
            rd_port_d  = gnt1;
        end
        // RAM read is combinational, so the issued read's data is on
        // ram_data_out during the issue cycle and is captured at its end.
        rvalid0_d = rd_vld_q & (rd_port_q == PORT_CPU);
        rvalid1_d = rd_vld_q & (rd_port_q == PORT_LDR);
        rdata0_d  = rvalid0_d ? ram_data_out : rdata0_q;
        rdata1_d  = rvalid1_d ? ram_data_out : rdata1_q;
    end

    // State registers; reset drops the in-flight tag so no stale rvalid fires.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q     <= 1'b1;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            rd_vld_q   <= 1'b0;
            rd_port_q  <= 1'b0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            last_q     <= last_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            rd_vld_q   <= rd_vld_d;
            rd_port_q  <= rd_port_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

    assign ram_write_enable = ram_we_q;
    assign ram_address      = ram_addr_q;
    assign ram_data_in      = ram_din_q;
    assign rvalid0          = rvalid0_q;
    assign rvalid1          = rvalid1_q;
    assign rdata0           = rdata0_q;
    assign rdata1           = rdata1_q;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Directed + random bench for data_ram_arbiter with a transaction-level
// model: grants from the round-robin rule, memory contents as an array.
module tb_data_ram_arbiter;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic          ram_write_enable;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data_in, ram_data_out;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    data_ram_arbiter dut (
        .clk              (clk),
        .reset            (reset),
        .req0             (req0),
        .we0              (we0),
        .addr0            (addr0),
        .wdata0           (wdata0),
        .req1             (req1),
        .we1              (we1),
        .addr1            (addr1),
        .wdata1           (wdata1),
        .gnt0             (gnt0),
        .gnt1             (gnt1),
        .rdata0           (rdata0),
        .rdata1           (rdata1),
        .rvalid0          (rvalid0),
        .rvalid1          (rvalid1),
        .ram_write_enable (ram_write_enable),
        .ram_address      (ram_address),
        .ram_data_in      (ram_data_in),
        .ram_data_out     (ram_data_out)
    );

    // Data_RAM: combinational read, write on the rising edge.
    logic [DW-1:0] ram [16];
    assign ram_data_out = ram[ram_address];
    always @(posedge clk) if (ram_write_enable) ram[ram_address] <= ram_data_in;

    // Reference model state
    logic [DW-1:0] mem_m [16];
    logic          last_m;
    logic          g0, g1;
    logic          d1_v, d1_p, d2_v, d2_p;
    logic [DW-1:0] d1_d, d2_d, exp_rd0, exp_rd1;
    logic          iss_we;
    logic [AW-1:0] iss_addr;
    logic [DW-1:0] iss_din;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        last_m = 1'b1;
        d1_v = 0; d1_p = 0; d1_d = 0;
        d2_v = 0; d2_p = 0; d2_d = 0;
        exp_rd0 = 0; exp_rd1 = 0;
        iss_we = 0; iss_addr = 0; iss_din = 0;
    endtask

    // One clock: check everything mid-cycle, advance the model, retire grants.
    task automatic tick();
        logic          p, w;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        @(negedge clk);
        g0 = req0 && (!req1 || last_m);
        g1 = req1 && !g0;
        chk("gnt0", gnt0, g0);
        chk("gnt1", gnt1, g1);
        chk("ram_we", ram_write_enable, iss_we);
        chk("ram_addr", ram_address, iss_addr);
        chk("ram_din", ram_data_in, iss_din);
        chk("rvalid0", rvalid0, d2_v && !d2_p);
        chk("rvalid1", rvalid1, d2_v && d2_p);
        if (d2_v && !d2_p) exp_rd0 = d2_d;
        if (d2_v &&  d2_p) exp_rd1 = d2_d;
        chk("rdata0", rdata0, exp_rd0);
        chk("rdata1", rdata1, exp_rd1);
        d2_v = d1_v; d2_p = d1_p; d2_d = d1_d;
        d1_v = 0;
        if (g0 || g1) begin
            p  = g1;
            w  = p ? we1 : we0;
            a  = p ? addr1 : addr0;
            wd = p ? wdata1 : wdata0;
            last_m = p;
            iss_we = w; iss_addr = a; iss_din = wd;
            if (w) mem_m[a] = wd;
            else begin d1_v = 1; d1_p = p; d1_d = mem_m[a]; end
        end else begin
            iss_we = 0;
        end
        @(posedge clk); #1;
        if (g0) req0 = 0;
        if (g1) req1 = 0;
    endtask

    task automatic set0(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req0 = 1; we0 = w; addr0 = a; wdata0 = d;
    endtask

    task automatic set1(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req1 = 1; we1 = w; addr1 = a; wdata1 = d;
    endtask

    // Run until both requests retire (bounded), then let returns land.
    task automatic drain();
        int n = 0;
        while ((req0 || req1) && n < 10) begin tick(); n++; end
        if (req0 || req1) chk("drain_timeout", 1, 0);
        tick(); tick();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin ram[i] = 0; mem_m[i] = 0; end
        reset = 1;
        req0 = 1; we0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 1; we1 = 0; addr1 = 0; wdata1 = 0;
        model_reset();
        #2;
        chk("rst_gnt0", gnt0, 0);
        chk("rst_gnt1", gnt1, 0);
        chk("rst_we", ram_write_enable, 0);
        chk("rst_addr", ram_address, 0);
        chk("rst_din", ram_data_in, 0);
        chk("rst_rvalid", {rvalid1, rvalid0}, 0);
        chk("rst_rdata", {rdata1, rdata0}, 0);
        req0 = 0; req1 = 0;
        @(posedge clk); @(posedge clk); #1;
        reset = 0;

        // Loader write then CPU read of the same word
        set1(1, 4'h1, 8'hFF); tick();
        set0(0, 4'h1, 8'h00); drain();
        chk("t1_rdata0", rdata0, 8'hFF);

        // Simultaneous writes, then simultaneous readback
        set0(1, 4'h2, 8'hAA); set1(1, 4'h3, 8'hF0); drain();
        set0(0, 4'h2, 8'h00); set1(0, 4'h3, 8'h00); drain();
        chk("t2_rdata0", rdata0, 8'hAA);
        chk("t2_rdata1", rdata1, 8'hF0);

        // Write followed immediately by read of the same address
        set0(1, 4'h4, 8'h55); tick();
        set0(0, 4'h4, 8'h00); drain();
        chk("t3_rdata0", rdata0, 8'h55);

        // Both ports reading continuously
        set0(0, 4'h1, 8'h00); set1(0, 4'h2, 8'h00);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (!req0) set0(0, 4'($urandom_range(0, 4)), 8'h00);
            if (!req1) set1(0, 4'($urandom_range(0, 4)), 8'h00);
        end
        drain();

        // Reset during the issue cycle of a loader read
        set1(0, 4'h3, 8'h00); tick();
        chk("t5_granted", g1, 1);
        req0 = 1;
        #2 reset = 1;
        #1;
        chk("t5_gnt0", gnt0, 0);
        chk("t5_we", ram_write_enable, 0);
        chk("t5_addr", ram_address, 0);
        chk("t5_din", ram_data_in, 0);
        chk("t5_rvalid", {rvalid1, rvalid0}, 0);
        chk("t5_rdata", {rdata1, rdata0}, 0);
        req0 = 0;
        @(posedge clk); #1;
        reset = 0;
        model_reset();
        tick(); tick(); tick();
        set0(0, 4'h2, 8'h00); set1(0, 4'h3, 8'h00); tick();
        chk("t5_first_after_rst", g0, 1);
        drain();

        // Top address, no wrap
        set0(1, 4'hF, 8'h3C); tick();
        set1(0, 4'hF, 8'h00); drain();
        chk("t6_rdata1", rdata1, 8'h3C);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            if (!req0 && $urandom_range(0, 3) != 0)
                set0(1'($urandom), 4'($urandom), 8'($urandom));
            if (!req1 && $urandom_range(0, 3) != 0)
                set1(1'($urandom), 4'($urandom), 8'($urandom));
            tick();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
